// File: rtl/dendy_bus.sv
// dendy_bus: CPU-side bus responder for the Dendy core.
// Decodes the 6502 address map, muxes read data back to the CPU, raises
// one-clock PPU/RAM strobes, runs the $4014 OAM DMA engine (stalling the CPU)
// and implements the $4016/$4017 joypad shift registers.
// Optional build macro DENDY_OPENBUS_EN: unmapped reads and the joypad upper
// bits come from an open-bus latch instead of fixed constants.
module dendy_bus #(
   parameter int         RAM_AW   = 11,
   parameter int         PRG_AW   = 15,
   parameter logic [7:0] OPEN_VAL = 8'hFF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ce_in,
   output logic              cpu_ce,
   input  logic [15:0]       cpu_a,
   input  logic [7:0]        cpu_d,
   input  logic              cpu_r,
   input  logic              cpu_w,
   output logic [7:0]        cpu_i,
   output logic [RAM_AW-1:0] ram_a,
   output logic [7:0]        ram_d,
   output logic              ram_we,
   input  logic [7:0]        ram_q,
   output logic [PRG_AW-1:0] prg_a,
   input  logic [7:0]        prg_q,
   output logic [2:0]        ppu_a,
   output logic [7:0]        ppu_d,
   output logic              ppu_r,
   output logic              ppu_w,
   input  logic [7:0]        ppu_q,
   input  logic [7:0]        joy1,
   input  logic [7:0]        joy2
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_ALIGN = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_WR    = 3'd4;

   localparam logic [2:0] R_NONE = 3'd0;
   localparam logic [2:0] R_RAM  = 3'd1;
   localparam logic [2:0] R_PPU  = 3'd2;
   localparam logic [2:0] R_JOY1 = 3'd3;
   localparam logic [2:0] R_JOY2 = 3'd4;
   localparam logic [2:0] R_PRG  = 3'd5;

   function automatic logic [2:0] decode(input logic [15:0] a);
      logic [2:0] r;
      if (a[15])                   r = R_PRG;
      else if (a[15:13] == 3'b000) r = R_RAM;
      else if (a[15:13] == 3'b001) r = R_PPU;
      else if (a == 16'h4016)      r = R_JOY1;
      else if (a == 16'h4017)      r = R_JOY2;
      else                         r = R_NONE;
      return r;
   endfunction

   logic [2:0] state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] dbuf_q, dbuf_d;
   logic       parity_q, parity_d;
   logic       strobe_q, strobe_d;
   logic [7:0] sh1_q, sh1_d;
   logic [7:0] sh2_q, sh2_d;
   logic [2:0] region_q, region_d;

   logic        idle;
   logic [15:0] m_addr;
   logic [7:0]  m_data;
   logic [2:0]  m_region;
   logic        m_rd;
   logic        rd_stb;
   logic        wr_stb;
   logic [6:0]  joy_hi;
   logic [7:0]  open_val;
   logic [7:0]  rdata;

   // The DMA engine owns the bus whenever it is not idle; only the CPU writes.
   assign idle     = (state_q == S_IDLE);
   assign m_addr   = idle ? cpu_a : {page_q, idx_q};
   assign m_data   = idle ? cpu_d : dbuf_q;
   assign m_region = decode(m_addr);
   assign m_rd     = idle ? cpu_r : (state_q == S_RD);
   assign rd_stb   = ce_in & m_rd;
   assign wr_stb   = ce_in & idle & cpu_w;

`ifdef DENDY_OPENBUS_EN
   logic [7:0] ob_q, ob_d;
   assign joy_hi   = ob_q[7:1];
   assign open_val = ob_q;
`else
   assign joy_hi   = 7'b0100000;
   assign open_val = OPEN_VAL;
`endif

   // Read-data mux on the region registered one clock after the address.
   always_comb begin
      case (region_q)
         R_RAM:   rdata = ram_q;
         R_PPU:   rdata = ppu_q;
         R_PRG:   rdata = prg_q;
         R_JOY1:  rdata = {joy_hi, sh1_q[0]};
         R_JOY2:  rdata = {joy_hi, sh2_q[0]};
         default: rdata = open_val;
      endcase
   end

   // Next-state logic: region tracking, parity, joypads and the DMA FSM.
   always_comb begin
      region_d = m_region;
      parity_d = parity_q ^ ce_in;
      strobe_d = strobe_q;
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      state_d  = state_q;
      page_d   = page_q;
      idx_d    = idx_q;
      dbuf_d   = dbuf_q;
`ifdef DENDY_OPENBUS_EN
      ob_d     = ob_q;
      if (ce_in && idle) ob_d = rdata;
`endif

      if (wr_stb && m_region == R_JOY1) strobe_d = cpu_d[0];

      // While strobed the pads are reloaded continuously; otherwise each
      // read shifts toward bit 0 and backfills with 1s.
      if (strobe_q) begin
         sh1_d = joy1;
         sh2_d = joy2;
      end else begin
         if (rd_stb && m_region == R_JOY1) sh1_d = {1'b1, sh1_q[7:1]};
         if (rd_stb && m_region == R_JOY2) sh2_d = {1'b1, sh2_q[7:1]};
      end

      case (state_q)
         S_IDLE: begin
            if (wr_stb && m_addr == 16'h4014) begin
               state_d = S_WAIT;
               page_d  = cpu_d;
               idx_d   = 8'd0;
            end
         end
         S_WAIT:  if (ce_in) state_d = parity_d ? S_ALIGN : S_RD;
         S_ALIGN: if (ce_in) state_d = S_RD;
         S_RD: begin
            if (ce_in) begin
               dbuf_d  = rdata;
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (ce_in) begin
               idx_d   = idx_q + 8'd1;
               state_d = (idx_q == 8'hFF) ? S_IDLE : S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         parity_q <= 1'b0;
         strobe_q <= 1'b0;
         sh1_q    <= 8'h00;
         sh2_q    <= 8'h00;
         region_q <= R_NONE;
`ifdef DENDY_OPENBUS_EN
         ob_q     <= 8'hFF;
`endif
      end else begin
         state_q  <= state_d;
         parity_q <= parity_d;
         strobe_q <= strobe_d;
         sh1_q    <= sh1_d;
         sh2_q    <= sh2_d;
         region_q <= region_d;
`ifdef DENDY_OPENBUS_EN
         ob_q     <= ob_d;
`endif
      end
   end

   // DMA datapath registers; only meaningful while the FSM is active.
   always_ff @(posedge clock) begin
      page_q <= page_d;
      idx_q  <= idx_d;
      dbuf_q <= dbuf_d;
   end

   // Bus outputs; held at zero in reset while cpu_ce still follows ce_in.
   always_comb begin
      cpu_ce = ce_in & (idle | ~reset_n);
      cpu_i  = 8'h00;
      ram_a  = '0;
      ram_d  = 8'h00;
      ram_we = 1'b0;
      prg_a  = '0;
      ppu_a  = 3'd0;
      ppu_d  = 8'h00;
      ppu_r  = 1'b0;
      ppu_w  = 1'b0;
      if (reset_n) begin
         cpu_i  = rdata;
         ram_a  = m_addr[RAM_AW-1:0];
         ram_d  = m_data;
         ram_we = wr_stb & (m_region == R_RAM);
         prg_a  = m_addr[PRG_AW-1:0];
         ppu_a  = (state_q == S_WR) ? 3'd4 : m_addr[2:0];
         ppu_d  = m_data;
         ppu_w  = (wr_stb & (m_region == R_PPU)) | (ce_in & (state_q == S_WR));
         ppu_r  = rd_stb & (m_region == R_PPU);
      end
   end

endmodule

// File: tb/tb_dendy_bus.sv
// tb_dendy_bus: directed table-driven bench for dendy_bus with RAM/PRG/PPU models.
module tb_dendy_bus;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_in   = 1'b0;
   logic        cpu_ce;
   logic [15:0] cpu_a   = 16'h0000;
   logic [7:0]  cpu_d   = 8'h00;
   logic        cpu_r   = 1'b0;
   logic        cpu_w   = 1'b0;
   logic [7:0]  cpu_i;
   logic [10:0] ram_a;
   logic [7:0]  ram_d;
   logic        ram_we;
   logic [7:0]  ram_q;
   logic [14:0] prg_a;
   logic [7:0]  prg_q;
   logic [2:0]  ppu_a;
   logic [7:0]  ppu_d;
   logic        ppu_r;
   logic        ppu_w;
   logic [7:0]  ppu_q;
   logic [7:0]  joy1 = 8'b1000_0001;
   logic [7:0]  joy2 = 8'hFF;

   logic [7:0]  mem [0:2047];

   int tests    = 0;
   int fails    = 0;
   int tick_cnt = 0;

   logic [7:0]  s_i, s_pd;
   logic        s_ce, s_we, s_pw, s_pr, pre_pr;
   logic [10:0] s_ra;
   logic [2:0]  s_pa;

`ifdef DENDY_OPENBUS_EN
   localparam logic [7:0] OPEN_EXP = 8'hA9;
`else
   localparam logic [7:0] OPEN_EXP = 8'hFF;
`endif

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        r, w, ci;
      logic [7:0]  ei;
      logic        we, pw, pr, ca;
      logic [10:0] ra;
      logic [2:0]  pa;
      logic [7:0]  pd;
      logic        jb;
   } vec_t;

   vec_t vq[$];

   always #20 clock = ~clock;

   dendy_bus dut (
      .clock(clock), .reset_n(reset_n), .ce_in(ce_in), .cpu_ce(cpu_ce),
      .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_i(cpu_i),
      .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
      .prg_a(prg_a), .prg_q(prg_q),
      .ppu_a(ppu_a), .ppu_d(ppu_d), .ppu_r(ppu_r), .ppu_w(ppu_w), .ppu_q(ppu_q),
      .joy1(joy1), .joy2(joy2)
   );

   // Synchronous RAM and PRG models, combinational PPU register file.
   always @(posedge clock) begin
      if (ram_we) mem[ram_a] <= ram_d;
      ram_q <= mem[ram_a];
      prg_q <= prg_a[7:0] + 8'hA9;
   end
   assign ppu_q = 8'hC0 | {5'd0, ppu_a};

   function automatic vec_t v(input logic [15:0] a, input logic [7:0] d, input logic r,
                              input logic w, input logic ci, input logic [7:0] ei,
                              input logic we, input logic pw, input logic pr, input logic ca,
                              input logic [10:0] ra, input logic [2:0] pa, input logic [7:0] pd,
                              input logic jb);
      vec_t t;
      t.a = a; t.d = d; t.r = r; t.w = w; t.ci = ci; t.ei = ei;
      t.we = we; t.pw = pw; t.pr = pr; t.ca = ca; t.ra = ra; t.pa = pa; t.pd = pd; t.jb = jb;
      return t;
   endfunction

   function automatic logic [7:0] exp_dma(input logic [7:0] page, input logic [7:0] idx);
      if (page == 8'h02)      return idx;
      else if (page == 8'h20) return 8'hC0 | {5'd0, idx[2:0]};
      else                    return 8'hFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One CPU cycle: address phase with ce low, then the ce clock; sample before the ce edge.
   task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
      @(negedge clock);
      cpu_a = a; cpu_d = d; cpu_r = r; cpu_w = w; ce_in = 1'b0;
      #1 pre_pr = ppu_r;
      @(negedge clock);
      ce_in = 1'b1;
      #1;
      s_i = cpu_i; s_ce = cpu_ce; s_we = ram_we; s_ra = ram_a;
      s_pw = ppu_w; s_pr = ppu_r; s_pa = ppu_a; s_pd = ppu_d;
      tick_cnt++;
   endtask

   task automatic align(input int par);
      if ((tick_cnt % 2) != par) cyc(16'h0000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic dma_run(input logic [7:0] page, input int want, input logic stop_mid);
      int stall, nw, bad, npr;
      logic reached;
      logic [7:0] ed;
      stall = 0; nw = 0; bad = 0; npr = 0; reached = 1'b0;
      cyc(16'h4014, page, 1'b0, 1'b1);
      for (int t = 0; t < 600; t++) begin
         cyc(16'h0000, 8'h00, 1'b0, 1'b0);
         if (stop_mid && nw >= 100 && (tick_cnt % 2) == 1) begin
            reached = 1'b1;
            break;
         end
         if (s_ce) break;
         stall++;
         if (s_pr) npr++;
         if (s_pw) begin
            ed = exp_dma(page, nw[7:0]);
            if (s_pa !== 3'd4 || s_pd !== ed) bad++;
            nw++;
         end
      end
      if (stop_mid) begin
         chk("dma mid-point reached", reached, 1);
         return;
      end
      chk($sformatf("dma page %02h stall ticks", page), stall, want);
      chk($sformatf("dma page %02h ppu_w count", page), nw, 256);
      chk($sformatf("dma page %02h data errors", page), bad, 0);
      chk($sformatf("dma page %02h ppu_r count", page), npr, (page == 8'h20) ? 256 : 0);
   endtask

   initial begin
      logic [7:0] msk;

      vq.push_back(v(16'h0805, 8'h5A, 0, 1, 0, 8'h00, 1, 0, 0, 1, 11'h005, 3'd5, 8'h00, 0));
      vq.push_back(v(16'h1005, 8'h00, 1, 0, 1, 8'h5A, 0, 0, 0, 1, 11'h005, 3'd5, 8'h00, 0));
      vq.push_back(v(16'h2006, 8'h3F, 0, 1, 0, 8'h00, 0, 1, 0, 1, 11'h006, 3'd6, 8'h3F, 0));
      vq.push_back(v(16'h2002, 8'h00, 1, 0, 1, 8'hC2, 0, 0, 1, 1, 11'h002, 3'd2, 8'h00, 0));
      vq.push_back(v(16'h3FFF, 8'h00, 1, 0, 1, 8'hC7, 0, 0, 1, 1, 11'h7FF, 3'd7, 8'h00, 0));
      vq.push_back(v(16'h8003, 8'h00, 1, 0, 1, 8'hAC, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'hFFFF, 8'h00, 1, 0, 1, 8'hA8, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h8000, 8'h00, 1, 0, 1, 8'hA9, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h5000, 8'h00, 1, 0, 1, OPEN_EXP, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h5000, 8'h12, 0, 1, 0, 8'h00, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h1FFF, 8'h77, 0, 1, 0, 8'h00, 1, 0, 0, 1, 11'h7FF, 3'd7, 8'h00, 0));
      vq.push_back(v(16'h07FF, 8'h00, 1, 0, 1, 8'h77, 0, 0, 0, 1, 11'h7FF, 3'd7, 8'h00, 0));
      vq.push_back(v(16'h4016, 8'h01, 0, 1, 0, 8'h00, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h4016, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 0));
      vq.push_back(v(16'h4016, 8'h00, 1, 0, 1, 8'h41, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 1));
      for (int k = 0; k < 6; k++)
         vq.push_back(v(16'h4016, 8'h00, 1, 0, 1, 8'h40, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 1));
      for (int k = 0; k < 3; k++)
         vq.push_back(v(16'h4016, 8'h00, 1, 0, 1, 8'h41, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 1));
      vq.push_back(v(16'h4017, 8'h00, 1, 0, 1, 8'h41, 0, 0, 0, 0, 11'h000, 3'd0, 8'h00, 1));

      // Reset with live-looking CPU activity: outputs must stay quiet.
      reset_n = 1'b0; cpu_a = 16'h2002; cpu_d = 8'h55; cpu_r = 1'b1; cpu_w = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      ce_in = 1'b1;
      #1;
      chk("reset cpu_ce follows ce_in high", cpu_ce, 1);
      chk("reset cpu_i", cpu_i, 0);
      chk("reset ram_we", ram_we, 0);
      chk("reset ppu_w", ppu_w, 0);
      chk("reset ppu_r", ppu_r, 0);
      chk("reset ppu_a", ppu_a, 0);
      chk("reset ram_a", ram_a, 0);
      @(negedge clock);
      ce_in = 1'b0;
      #1 chk("reset cpu_ce follows ce_in low", cpu_ce, 0);
      cpu_r = 1'b0; cpu_w = 1'b0; reset_n = 1'b1; tick_cnt = 0;

      foreach (vq[i]) begin
         cyc(vq[i].a, vq[i].d, vq[i].r, vq[i].w);
         msk = 8'hFF;
`ifdef DENDY_OPENBUS_EN
         if (vq[i].jb) msk = 8'h01;
`endif
         if (vq[i].ci) chk($sformatf("v%0d cpu_i", i), s_i & msk, vq[i].ei & msk);
         chk($sformatf("v%0d ram_we", i), s_we, vq[i].we);
         chk($sformatf("v%0d ppu_w", i), s_pw, vq[i].pw);
         chk($sformatf("v%0d ppu_r", i), s_pr, vq[i].pr);
         if (vq[i].ca) begin
            chk($sformatf("v%0d ram_a", i), s_ra, vq[i].ra);
            chk($sformatf("v%0d ppu_a", i), s_pa, vq[i].pa);
         end
         if (vq[i].pw) chk($sformatf("v%0d ppu_d", i), s_pd, vq[i].pd);
         if (vq[i].pr) chk($sformatf("v%0d ppu_r before ce", i), pre_pr, 0);
      end

      // Fill $0200-$02FF with its own index, then DMA it out.
      for (int k = 0; k < 256; k++) cyc(16'h0200 + 16'(k), 8'(k), 1'b0, 1'b1);

      align(0); dma_run(8'h02, 513, 1'b0);
      align(1); dma_run(8'h02, 514, 1'b0);
      align(0); dma_run(8'h20, 513, 1'b0);
`ifndef DENDY_OPENBUS_EN
      align(0); dma_run(8'h50, 513, 1'b0);
`endif

      // Reset in the middle of a DMA with the parity flop set.
      align(0); dma_run(8'h02, 0, 1'b1);
      @(negedge clock);
      reset_n = 1'b0; ce_in = 1'b1;
      #1;
      chk("mid-dma reset cpu_ce", cpu_ce, 1);
      chk("mid-dma reset ppu_w", ppu_w, 0);
      @(negedge clock);
      ce_in = 1'b0; reset_n = 1'b1; tick_cnt = 0;
      #1 chk("post reset cpu_ce idle", cpu_ce, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(16'h0000, 8'h00, 1'b0, 1'b0);
         chk($sformatf("post reset tick%0d cpu_ce", k), s_ce, 1);
         chk($sformatf("post reset tick%0d ppu_w", k), s_pw, 0);
      end
      cyc(16'h4017, 8'h00, 1'b1, 1'b0);
`ifdef DENDY_OPENBUS_EN
      chk("post reset pad2 bit", s_i[0], 0);
`else
      chk("post reset pad2 read", s_i, 8'h40);
`endif
      align(0); dma_run(8'h02, 513, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dendy_bus.md
Name: dendy_bus

Overview:
CPU-side bus responder for the Dendy core. It sits between the 6502 core's memory interface (A/D/I/R/W, ce) and the system memories and peripherals. It decodes the CPU address map and returns read data on I. It generates single-clock side-effect strobes for PPU registers. It implements the $4014 OAM DMA engine, which stalls the CPU, and the $4016/$4017 joypad serial shift registers.

Parameters:
RAM_AW, 11, internal RAM address width (2 KB, mirrored over $0000-$1FFF)
PRG_AW, 15, PRG ROM address width ($8000-$FFFF)
OPEN_VAL, 8'hFF, read value for unmapped addresses when open bus is disabled

Ports:
clock  in  1  system clock, 25 MHz
reset_n  in  1  synchronous active-low reset
ce_in  in  1  CPU tick; pulses at most every 2nd clock
cpu_ce  out  1  ce forwarded to the CPU; gated low during DMA
cpu_a  in  16  CPU address
cpu_d  in  8  CPU write data
cpu_r  in  1  CPU read strobe
cpu_w  in  1  CPU write strobe
cpu_i  out  8  read data to CPU
ram_a  out  RAM_AW  RAM address
ram_d  out  8  RAM write data
ram_we  out  1  RAM write enable, one clock
ram_q  in  8  RAM read data, 1-clock synchronous latency
prg_a  out  PRG_AW  PRG address
prg_q  in  8  PRG read data, 1-clock latency
ppu_a  out  3  PPU register index
ppu_d  out  8  PPU write data
ppu_r  out  1  PPU read strobe, one clock
ppu_w  out  1  PPU write strobe, one clock
ppu_q  in  8  PPU register read data, combinational
joy1  in  8  pad 1 buttons {Right,Left,Down,Up,Start,Select,B,A}, 1 = pressed
joy2  in  8  pad 2 buttons, same order

Behaviour:
- Reset: reset_n is synchronous, active-low, clock is clock. All outputs are 0 except cpu_ce, which follows ce_in. DMA state is IDLE, joypad shift registers are 0, strobe latch is 0, parity is 0, open-bus latch is 8'hFF.
- Bus master: the CPU (cpu_a, cpu_d) when DMA is IDLE; otherwise the DMA address and data.
- Address map, by master address:
  - $0000-$1FFF: RAM, ram_a = addr[10:0].
  - $2000-$3FFF: PPU, ppu_a = addr[2:0].
  - $4014: DMA trigger.
  - $4016, $4017: joypads.
  - $8000-$FFFF: PRG, prg_a = addr[14:0].
  - Everything else is unmapped; writes are ignored.
- Read data: the region is registered every clock from the master address. cpu_i is a combinational mux on that registered region, so it is valid one clock after the address settles and before the next ce_in.
  - $4016/$4017 return {7'b0100000, bit}; the upper bits are the open-bus pattern.
- Strobes, all qualified by ce_in, each 1 clock wide:
  - ram_we = cpu_w & RAM region.
  - ppu_w = cpu_w & PPU region.
  - ppu_r = cpu_r & PPU region; marks consumption for read side effects.
- Parity: a toggle flip-flop flips on every ce_in and is used for DMA alignment.
- Joypad:
  - Write $4016: strobe <= cpu_d[0].
  - While strobe=1, sh1 <= joy1 and sh2 <= joy2 every clock; a read returns bit0 (A).
  - While strobe=0, a read of $4016 (cpu_r & ce_in) returns sh1[0], then sh1 <= {1'b1, sh1[7:1]}. $4017 does the same with sh2.
  - After 8 reads every further read returns 1.
- DMA FSM, states IDLE, WAIT, ALIGN, RD, WR:
  - IDLE -> WAIT on cpu_w & ce_in & addr==$4014; page <= cpu_d, idx <= 0. cpu_ce is forced 0 from the next clock.
  - WAIT -> RD on the next ce_in if parity is even after the toggle; otherwise WAIT -> ALIGN -> RD.
  - RD (one ce): source address {page, idx}, decoded through the same map. The byte is latched into dbuf at the ce edge.
  - WR (one ce): ppu_a = 3'd4, ppu_d = dbuf, ppu_w pulsed; idx <= idx+1. On idx==255 -> IDLE, else -> RD.
  - Total stall is 513 (even) or 514 (odd) ce ticks. cpu_ce resumes on the ce_in after the last WR.
- Boundary and corner cases:
  - A CPU write to $4014 while DMA is active is impossible, because the CPU is stalled.
  - DMA from page $20-$3F reads PPU registers and raises ppu_r.
  - DMA from an unmapped page reads the open value.
  - idx wraps at 255 with exit; the page never increments.
  - Reset mid-DMA returns to IDLE immediately with no further ppu_w.
  - Writes to $4016 while DMA is active are not possible.

Optional Feature:
DENDY_OPENBUS_EN.
- Defined: an open-bus latch captures cpu_i on every ce_in while the CPU is master. Unmapped reads return the latch, and the $4016/$4017 upper 7 bits come from the latch.
- Undefined: unmapped reads return OPEN_VAL, and the joypad upper bits are the fixed 7'b0100000.

Test Plan:
- CPU write $0805 = 8'h5A, then read $1005 -> ram_a = 11'h005 both times; cpu_i = 8'h5A (mirror).
- Write $2006 = 8'h3F, then read $2002 -> one ppu_w with ppu_a = 6, ppu_d = 8'h3F; one ppu_r 1 clock wide with ppu_a = 2; cpu_i = ppu_q.
- joy1 = 8'b1000_0001; write $4016 = 1 then 0; 10 reads of $4016 -> bits 1,0,0,0,0,0,0,1,1,1 (with DENDY_OPENBUS_EN undefined, cpu_i = 8'h41/8'h40).
- RAM $0200-$02FF = i; write $4014 = 8'h02 on an even parity tick -> cpu_ce low for exactly 513 ce ticks; 256 ppu_w with ppu_a = 4 and data 0..255 in order. Repeat on an odd tick -> 514.
- Assert reset_n = 0 mid-DMA at idx = 100 -> next clock DMA is IDLE, cpu_ce = ce_in, no further ppu_w, joypad registers and parity cleared.
- Read $5000 -> cpu_i = 8'hFF with the macro undefined; with DENDY_OPENBUS_EN defined, read $8000 (prg_q = 8'hA9) then $5000 -> 8'hA9.
